// File: rtl/mem_responder_pkg.sv
// Shared constants and write-arbitration types for the byte memory responder.
// Optional write-first read bypass is enabled by defining MEM_BYPASS_EN.
package robin_mem_pkg;
  localparam int ADDR_WIDTH = 9;
  localparam int START_VEC_HI = 0;
  localparam int START_VEC_LO = 1;
  localparam int RESULT_ADDR_BASE = 2;
  localparam int RESULT_BYTES = 4;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_HOST,
    WR_CPU
  } wr_src_e;

  function automatic wr_src_e wr_pick(
    input logic host_we,
    input logic cpu_we
  );
    wr_src_e src;
    src = WR_NONE;
    unique case (1'b1)
      host_we: src = WR_HOST;
      (cpu_we && !host_we): src = WR_CPU;
      default: src = WR_NONE;
    endcase
    return src;
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// CPU read/write and host load/inspect bus of the memory responder.
// The master drives requests, the slave is the responder.
import robin_mem_pkg::*;

interface mem_responder_if #(
  parameter int addr_width = ADDR_WIDTH
);
  logic [addr_width-1:0] mem_raddr;
  logic [7:0]            mem_data_out;
  logic                  mem_ready;
  logic [addr_width-1:0] mem_waddr;
  logic [7:0]            mem_data_in;
  logic                  mem_write;
  logic [addr_width-1:0] host_addr;
  logic [7:0]            host_wdata;
  logic                  host_we;
  logic [7:0]            host_rdata;
  logic                  write_conflict;

  modport master (
    output mem_raddr, mem_waddr,
    output mem_data_in, mem_write,
    output host_addr, host_wdata,
    output host_we,
    input  mem_data_out, mem_ready,
    input  host_rdata, write_conflict
  );

  modport slave (
    input  mem_raddr, mem_waddr,
    input  mem_data_in, mem_write,
    input  host_addr, host_wdata,
    input  host_we,
    output mem_data_out, mem_ready,
    output host_rdata, write_conflict
  );
endinterface

// File: rtl/mem_lat_pipe.sv
// Read-data delay chain of 'latency' registers.
// Synchronous clear empties every stage.
module mem_lat_pipe #(
  parameter int latency = 1,
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);
  logic [width-1:0] stg [latency];

  // Shift one stage per cycle, clear all on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < latency; i++)
        stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < latency; i++)
        stg[i] <= stg[i-1];
    end
  end

  assign q = stg[latency-1];
endmodule

// File: rtl/mem_responder.sv
// Byte memory with CPU read/write port and host load port.
// MEM_BYPASS_EN selects write-first reads; default is read-first.
import robin_mem_pkg::*;

module mem_responder #(
  parameter int addr_width = ADDR_WIDTH,
  parameter int read_latency = 1
) (
  input logic clk,
  input logic reset,
  mem_responder_if.slave bus
);
  localparam int depth = 2**addr_width;
  localparam logic [CNT_W-1:0] LAT =
    CNT_W'(read_latency);

  logic [7:0] mem [depth];

  wr_src_e               wr_src;
  logic                  wr_en;
  logic [addr_width-1:0] wr_addr;
  logic [7:0]            wr_data;
  logic [7:0]            rd_byte;
  logic [7:0]            host_byte;
  logic [addr_width-1:0] prev_raddr;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_eff;
  logic [7:0]            host_q;
  logic                  conflict_q;

  // Host wins the single write port; CPU write is dropped on collision
  always_comb begin
    wr_src  = wr_pick(bus.host_we, bus.mem_write);
    wr_en   = 1'b0;
    wr_addr = bus.host_addr;
    wr_data = bus.host_wdata;
    unique case (wr_src)
      WR_HOST: wr_en = 1'b1;
      WR_CPU: begin
        wr_en   = 1'b1;
        wr_addr = bus.mem_waddr;
        wr_data = bus.mem_data_in;
      end
      default: wr_en = 1'b0;
    endcase
  end

  // Array update; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // Array read, optionally forwarding the byte being written
  always_comb begin
    rd_byte   = mem[bus.mem_raddr];
    host_byte = mem[bus.host_addr];
`ifdef MEM_BYPASS_EN
    if (wr_en && (wr_addr == bus.mem_raddr))
      rd_byte = wr_data;
    if (wr_en && (wr_addr == bus.host_addr))
      host_byte = wr_data;
`endif
  end

  assign cnt_eff =
    (bus.mem_raddr != prev_raddr) ? '0 : cnt_q;
  assign bus.mem_ready = (cnt_eff == LAT);

  // Ready counter: cycles the current address has been sampled
  always_ff @(posedge clk) begin
    prev_raddr <= bus.mem_raddr;
    if (reset)
      cnt_q <= '0;
    else if (cnt_eff != LAT)
      cnt_q <= cnt_eff + CNT_W'(1);
    else
      cnt_q <= cnt_eff;
  end

  // Host read register and dropped-write pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      host_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      host_q     <= host_byte;
      conflict_q <= bus.host_we & bus.mem_write;
    end
  end

  assign bus.host_rdata     = host_q;
  assign bus.write_conflict = conflict_q;

  mem_lat_pipe #(
    .latency(read_latency),
    .width(8)
  ) u_pipe (
    .clk(clk),
    .reset(reset),
    .d(rd_byte),
    .q(bus.mem_data_out)
  );
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency 1 and latency 3 instances.
// Expected values are hand-computed; read mode follows MEM_BYPASS_EN.
module tb_mem_responder;
  import robin_mem_pkg::*;

`ifdef MEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [8:0] ra;
    logic [8:0] wa;
    logic [7:0] wd;
    logic       mw;
    logic [8:0] ha;
    logic [7:0] hd;
    logic       hw;
    logic [7:0] ed;
    logic       er;
    logic [7:0] eh;
    logic       ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int checks = 0;
  int errors = 0;
  int n;
  vec_t tv [18];
  logic [7:0] init [8];

  mem_responder_if #(.addr_width(9)) b1();
  mem_responder_if #(.addr_width(9)) b3();

  mem_responder #(
    .addr_width(9),
    .read_latency(1)
  ) u1 (
    .clk(clk),
    .reset(rst1),
    .bus(b1)
  );

  mem_responder #(
    .addr_width(9),
    .read_latency(3)
  ) u3 (
    .clk(clk),
    .reset(rst3),
    .bus(b3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string nm,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [8:0] ra,
    input logic [8:0] wa,
    input logic [7:0] wd,
    input logic mw,
    input logic [8:0] ha,
    input logic [7:0] hd,
    input logic hw,
    input logic [7:0] ed,
    input logic er,
    input logic [7:0] eh,
    input logic ec
  );
    vec_t v;
    v.ra = ra; v.wa = wa; v.wd = wd;
    v.mw = mw; v.ha = ha; v.hd = hd;
    v.hw = hw; v.ed = ed; v.er = er;
    v.eh = eh; v.ec = ec;
    return v;
  endfunction

  task automatic chk_rst(
    input string nm,
    input logic [7:0] d,
    input logic r,
    input logic [7:0] h,
    input logic c
  );
    chk({nm, "_data"}, d, 8'h00);
    chk({nm, "_ready"}, {7'd0, r}, 8'h00);
    chk({nm, "_hrd"}, h, 8'h00);
    chk({nm, "_conf"}, {7'd0, c}, 8'h00);
  endtask

  initial begin
    init[0] = 8'h12; init[1] = 8'h34;
    init[2] = 8'h56; init[3] = 8'h78;
    init[4] = 8'h9A; init[5] = 8'hBC;
    init[6] = 8'hDE; init[7] = 8'hF0;

    // ra wa wd mw ha hd hw | ed er eh ec
    tv[0]  = mk(0, 0, 0, 0, 0, 0, 0,
                8'h12, 1, 8'h12, 0);
    tv[1]  = mk(1, 0, 0, 0, 1, 0, 0,
                8'h34, 1, 8'h34, 0);
    tv[2]  = mk(1, 0, 0, 0, 2, 0, 0,
                8'h34, 1, 8'h56, 0);
    tv[3]  = mk(1, 4, 8'h55, 1, 4, 8'hAA, 1,
                8'h34, 1, BYP ? 8'hAA : 8'h9A, 1);
    tv[4]  = mk(4, 0, 0, 0, 4, 0, 0,
                8'hAA, 1, 8'hAA, 0);
    tv[5]  = mk(5, 5, 8'h22, 1, 6, 8'h11, 1,
                8'hBC, 1, BYP ? 8'h11 : 8'hDE, 1);
    tv[6]  = mk(5, 0, 0, 0, 5, 0, 0,
                8'hBC, 1, 8'hBC, 0);
    tv[7]  = mk(2, 2, 8'h7E, 1, 3, 0, 0,
                BYP ? 8'h7E : 8'h56, 1, 8'h78, 0);
    tv[8]  = mk(2, 0, 0, 0, 2, 0, 0,
                8'h7E, 1, 8'h7E, 0);
    tv[9]  = mk(2, 0, 0, 0, 2, 8'h5A, 1,
                BYP ? 8'h5A : 8'h7E, 1,
                BYP ? 8'h5A : 8'h7E, 0);
    tv[10] = mk(7, 2, 8'h00, 1, 2, 0, 0,
                8'hF0, 1, BYP ? 8'h00 : 8'h5A, 0);
    tv[11] = mk(7, 3, 8'h00, 1, 3, 0, 0,
                8'hF0, 1, BYP ? 8'h00 : 8'h78, 0);
    tv[12] = mk(7, 4, 8'h01, 1, 4, 0, 0,
                8'hF0, 1, BYP ? 8'h01 : 8'hAA, 0);
    tv[13] = mk(7, 5, 8'h0A, 1, 5, 0, 0,
                8'hF0, 1, BYP ? 8'h0A : 8'hBC, 0);
    tv[14] = mk(7, 0, 0, 0, 2, 0, 0,
                8'hF0, 1, 8'h00, 0);
    tv[15] = mk(7, 0, 0, 0, 3, 0, 0,
                8'hF0, 1, 8'h00, 0);
    tv[16] = mk(7, 0, 0, 0, 4, 0, 0,
                8'hF0, 1, 8'h01, 0);
    tv[17] = mk(7, 0, 0, 0, 5, 0, 0,
                8'hF0, 1, 8'h0A, 0);

    rst1 = 1'b1;
    rst3 = 1'b1;
    b1.mem_raddr = '0;  b3.mem_raddr = 9'd5;
    b1.mem_waddr = '0;  b3.mem_waddr = '0;
    b1.mem_data_in = '0; b3.mem_data_in = '0;
    b1.mem_write = 1'b0; b3.mem_write = 1'b0;
    b1.host_addr = '0;  b3.host_addr = '0;
    b1.host_wdata = '0; b3.host_wdata = '0;
    b1.host_we = 1'b0;  b3.host_we = 1'b0;
    tick();
    tick();
    chk_rst("rst1", b1.mem_data_out, b1.mem_ready,
            b1.host_rdata, b1.write_conflict);
    chk_rst("rst3", b3.mem_data_out, b3.mem_ready,
            b3.host_rdata, b3.write_conflict);
    rst1 = 1'b0;
    rst3 = 1'b0;

    for (int i = 0; i < 8; i++) begin
      b1.host_addr = 9'(i);
      b1.host_wdata = init[i];
      b1.host_we = 1'b1;
      b3.host_we = (i < 2);
      b3.host_addr = 9'(5 + i);
      b3.host_wdata = 8'(8'h65 + i);
      tick();
    end
    b1.host_we = 1'b0;
    b3.host_we = 1'b0;
    b1.host_addr = 9'd7;
    tick();

    for (int i = 0; i < 18; i++) begin
      b1.mem_raddr = tv[i].ra;
      b1.mem_waddr = tv[i].wa;
      b1.mem_data_in = tv[i].wd;
      b1.mem_write = tv[i].mw;
      b1.host_addr = tv[i].ha;
      b1.host_wdata = tv[i].hd;
      b1.host_we = tv[i].hw;
      tick();
      chk($sformatf("v%0d_data", i),
          b1.mem_data_out, tv[i].ed);
      chk($sformatf("v%0d_ready", i),
          {7'd0, b1.mem_ready}, {7'd0, tv[i].er});
      chk($sformatf("v%0d_hrd", i),
          b1.host_rdata, tv[i].eh);
      chk($sformatf("v%0d_conf", i),
          {7'd0, b1.write_conflict},
          {7'd0, tv[i].ec});
    end
    b1.mem_write = 1'b0;
    b1.host_we = 1'b0;

    b1.mem_raddr = 9'd1;
    #1;
    chk("l1_step_ready", {7'd0, b1.mem_ready}, 8'h00);
    tick();
    chk("l1_step_ready2", {7'd0, b1.mem_ready}, 8'h01);
    chk("l1_step_data", b1.mem_data_out, 8'h34);

    chk("l3_hold_ready", {7'd0, b3.mem_ready}, 8'h01);
    chk("l3_hold_data", b3.mem_data_out, 8'h65);
    b3.mem_raddr = 9'd6;
    b3.host_addr = 9'd6;
    #1;
    chk("l3_step_ready", {7'd0, b3.mem_ready}, 8'h00);
    n = 0;
    while (n < 8 && !b3.mem_ready) begin
      tick();
      n++;
      if (n == 1)
        chk("l3_hrd_lat", b3.host_rdata, 8'h66);
      if (n < 3)
        chk($sformatf("l3_old_%0d", n),
            b3.mem_data_out, 8'h65);
    end
    chk("l3_edges", 8'(n), 8'd3);
    chk("l3_data", b3.mem_data_out, 8'h66);

    rst3 = 1'b1;
    b3.host_addr = 9'd7;
    b3.host_wdata = 8'h77;
    b3.host_we = 1'b1;
    tick();
    b3.host_we = 1'b0;
    chk_rst("mid1", b3.mem_data_out, b3.mem_ready,
            b3.host_rdata, b3.write_conflict);
    tick();
    chk_rst("mid2", b3.mem_data_out, b3.mem_ready,
            b3.host_rdata, b3.write_conflict);
    rst3 = 1'b0;
    n = 0;
    while (n < 8 && !b3.mem_ready) begin
      tick();
      n++;
    end
    chk("rel_edges", 8'(n), 8'd3);
    chk("rel_data", b3.mem_data_out, 8'h66);
    chk("rel_hrd7", b3.host_rdata, 8'h77);
    b3.host_addr = 9'd5;
    tick();
    chk("rel_hrd5", b3.host_rdata, 8'h65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter addr_width, default 9, byte-address width on every port; depth 2**addr_width bytes.
REQ-002 Parameter read_latency, default 1, range 1..4, cycles from stable mem_raddr to valid mem_data_out.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_raddr  input  addr_width  CPU read address.
REQ-006 mem_data_out  output  8  read data to CPU, registered.
REQ-007 mem_ready  output  1  high when mem_data_out corresponds to the current mem_raddr.
REQ-008 mem_waddr  input  addr_width  CPU write address.
REQ-009 mem_data_in  input  8  CPU write data.
REQ-010 mem_write  input  1  CPU write strobe, single-cycle qualifier.
REQ-011 host_addr  input  addr_width  host load/inspect address.
REQ-012 host_wdata  input  8  host write data.
REQ-013 host_we  input  1  host write strobe.
REQ-014 host_rdata  output  8  host read data, one cycle after host_addr.
REQ-015 write_conflict  output  1  one-cycle pulse when a CPU write was dropped.

Function
REQ-016 Read path samples mem_raddr every cycle; data pipeline of read_latency registers delivers mem[mem_raddr] read_latency cycles later.
REQ-017 Ready counter clears to 0 when mem_raddr differs from the previous cycle's value, increments saturating at read_latency; mem_ready = (count == read_latency).
REQ-018 With read_latency=1 and mem_raddr stable, mem_data_out is valid the cycle after the address is presented (CPU fetch timing with no ready check).
REQ-019 CPU write: when mem_write=1, mem[mem_waddr] <= mem_data_in on that edge.
REQ-020 Host write: when host_we=1, mem[host_addr] <= host_wdata on that edge.
REQ-021 Simultaneous host_we and mem_write: host write wins; CPU write dropped; write_conflict pulses next cycle, regardless of address equality.
REQ-022 Read-during-write to the same address: behaviour per REQ-027/REQ-028.
REQ-023 Writes do not affect the ready counter; a write to the address being read leaves mem_ready unchanged.
REQ-024 Addresses wrap naturally at addr_width bits; no out-of-range condition exists.
REQ-025 host_rdata = mem[host_addr] registered, latency 1, independent of read_latency.

Reset
REQ-026 On reset: mem_data_out=0, host_rdata=0, mem_ready=0, write_conflict=0, ready counter=0, data pipeline cleared; memory contents retained; writes presented in the reset cycle are still performed; reset mid-read restarts the latency count.

Configuration
REQ-027 With MEM_BYPASS_EN defined: a CPU or host write to the address currently read returns the new byte (write-first) on mem_data_out/host_rdata.
REQ-028 Without MEM_BYPASS_EN: read-first; old byte is returned, new byte visible on the next read.

Structure
REQ-029 Package robin_mem_pkg: ADDR_WIDTH default (9), START_VEC_HI=0, START_VEC_LO=1, RESULT_ADDR_BASE=2, RESULT_BYTES=4.
REQ-030 One sub-module, mem_lat_pipe: parameterised read_latency data register chain with clear.

Verification
REQ-031 Host writes 0x12@0, 0x34@1; CPU raddr=0 then 1 -> mem_data_out 0x12 then 0x34, one cycle each, mem_ready=1 each cycle after the address step.
REQ-032 read_latency=3, raddr changes 5->6 -> mem_ready low 3 cycles, then high with mem[6].
REQ-033 Simultaneous host_we (0xAA@4) and mem_write (0x55@4) -> mem[4]=0xAA, write_conflict=1 for one cycle.
REQ-034 raddr=2 stable, mem_write 0x7E@2 -> with MEM_BYPASS_EN mem_data_out=0x7E next cycle; without, old value then 0x7E.
REQ-035 CPU writes 0x00,0x00,0x01,0x0A @2..5 -> host reads 2..5 return 0x00,0x00,0x01,0x0A.
REQ-036 Reset asserted with raddr stable and read in flight -> outputs 0 during reset, mem_ready returns read_latency cycles after release, memory contents unchanged.
